// File: rtl/flashrom_reader.sv
// Purpose : sequential byte reader for the user flash ROM, packing bytes into WORD_BYTES-wide words.
// Latency : request to first word is WORD_BYTES*ROM_LATENCY cycles; each later word takes the same.
// Backpres: none; data is valid only in the data_valid cycle, and req is ignored while busy.
//
// Ports:
//   clk, rst              rising-edge clock, synchronous active-high reset
//   req, req_addr,        start request (sampled only when idle), first byte address,
//   req_words             number of words to read (0 gives a bare done pulse)
//   busy                  high from request acceptance until the edge that returns the last word
//   data, data_valid      assembled word and its one-cycle strobe; data holds between strobes
//   done                  one-cycle end-of-request strobe, coincident with the last data_valid
//   rom_addr, rom_dout    registered byte address to the ROM wrapper, and the byte it returns
module flashrom_reader #(
    parameter int ADDR_WIDTH  = 7,
    parameter int WORD_BYTES  = 2,
    parameter int ROM_LATENCY = 1,
    parameter int BIG_ENDIAN  = 0,
    parameter int COUNT_WIDTH = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    req,
    input  logic [ADDR_WIDTH-1:0]   req_addr,
    input  logic [COUNT_WIDTH-1:0]  req_words,
    output logic                    busy,
    output logic [8*WORD_BYTES-1:0] data,
    output logic                    data_valid,
    output logic                    done,
    output logic [ADDR_WIDTH-1:0]   rom_addr,
    input  logic [7:0]              rom_dout
);

    localparam int IDX_W  = (WORD_BYTES > 1)  ? $clog2(WORD_BYTES)  : 1;
    localparam int WAIT_W = (ROM_LATENCY > 1) ? $clog2(ROM_LATENCY) : 1;

    localparam logic [IDX_W-1:0]       LAST_IDX  = IDX_W'(WORD_BYTES - 1);
    localparam logic [WAIT_W-1:0]      LAST_WAIT = WAIT_W'(ROM_LATENCY - 1);
    localparam logic [COUNT_WIDTH-1:0] ONE_WORD  = COUNT_WIDTH'(1);

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        NOOP
    } state_t;

    state_t                   state;
    logic [8*WORD_BYTES-1:0]  acc;         // bytes of the word collected so far
    logic [IDX_W-1:0]         byte_idx;    // position of the next byte within the word
    logic [WAIT_W-1:0]        wait_cnt;    // edges elapsed since the last rom_addr update
    logic [COUNT_WIDTH-1:0]   words_left;

    logic [IDX_W-1:0]         slot;
    logic [8*WORD_BYTES-1:0]  word_next;

    // The partial word with the byte arriving this cycle dropped into its slot.
    // On the last byte of a word this is the complete word, so the data register
    // can be loaded on the same edge that captures that byte.
    always_comb begin
        slot      = (BIG_ENDIAN != 0) ? (LAST_IDX - byte_idx) : byte_idx;
        word_next = acc;
        for (int b = 0; b < WORD_BYTES; b++) begin
            if (slot == IDX_W'(b)) begin
                word_next[8*b +: 8] = rom_dout;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            busy       <= 1'b0;
            data       <= '0;
            data_valid <= 1'b0;
            done       <= 1'b0;
            rom_addr   <= '0;
            acc        <= '0;
            byte_idx   <= '0;
            wait_cnt   <= '0;
            words_left <= '0;
        end else begin
            data_valid <= 1'b0;
            done       <= 1'b0;

            case (state)
                IDLE: begin
                    if (req) begin
                        if (req_words != '0) begin
                            rom_addr   <= req_addr;
                            words_left <= req_words;
                            byte_idx   <= '0;
                            wait_cnt   <= '0;
                            acc        <= '0;
                            busy       <= 1'b1;
                            state      <= FETCH;
                        end else begin
                            // Zero-length request: only a done pulse, one cycle later.
                            state <= NOOP;
                        end
                    end
                end

                NOOP: begin
                    done  <= 1'b1;
                    state <= IDLE;
                end

                FETCH: begin
                    if (wait_cnt != LAST_WAIT) begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end else begin
                        // rom_dout now reflects rom_addr; take it and move on.
                        // The address wraps naturally at 2^ADDR_WIDTH.
                        wait_cnt <= '0;
                        rom_addr <= rom_addr + 1'b1;
                        if (byte_idx == LAST_IDX) begin
                            data       <= word_next;
                            data_valid <= 1'b1;
                            acc        <= '0;
                            byte_idx   <= '0;
                            words_left <= words_left - 1'b1;
                            if (words_left == ONE_WORD) begin
                                done  <= 1'b1;
                                busy  <= 1'b0;
                                state <= IDLE;
                            end
                        end else begin
                            acc      <= word_next;
                            byte_idx <= byte_idx + 1'b1;
                        end
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
